// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue with flush and branch predecode
// Circular buffer of {pc, inst}; outputs are driven from registered state only.
module if_id_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_is_branch,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [6:0]    OP_BRANCH = 7'b1100011;

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [63:0]   head;

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      // push and pop together cancel, leaving the count unchanged
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {in_pc, in_inst};
  end

  assign head          = mem_q[rp_q];
  assign out_pc        = out_valid ? head[63:32] : 32'h0;
  assign out_inst      = out_valid ? head[31:0]  : NOP;
  assign out_is_branch = out_valid & (head[6:0] == OP_BRANCH);
  assign count         = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_is_branch;
  logic        out_ready;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  if_id_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_is_branch(out_is_branch), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [63:0] h;
    logic        br;
    check({ph, ".count"},    64'(count),    64'(sb.size()));
    check({ph, ".in_ready"}, 64'(in_ready), 64'(sb.size() < DEPTH));
    check({ph, ".out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      h  = sb[0];
      br = (h[6:0] == 7'b1100011);
      check({ph, ".out_pc"},   64'(out_pc),   64'(h[63:32]));
      check({ph, ".out_inst"}, 64'(out_inst), 64'(h[31:0]));
      check({ph, ".is_branch"}, 64'(out_is_branch), 64'(br));
    end else begin
      check({ph, ".out_pc"},   64'(out_pc),   64'h0);
      check({ph, ".out_inst"}, 64'(out_inst), 64'(NOP));
      check({ph, ".is_branch"}, 64'(out_is_branch), 64'h0);
    end
  endtask

  // One clock: drive inputs, check head against model, update model, advance to next negedge.
  task automatic cycle(input string ph, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy, input logic fl);
    int sz;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    check_outputs(ph);
    sz = sb.size();
    if (fl) begin
      sb.delete();
    end else begin
      if (ordy && sz > 0) void'(sb.pop_front());
      if (v && sz < DEPTH) sb.push_back({pc, inst});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;
    cycle("idle", 0, 32'h0, 32'h0, 0, 0);

    cycle("fill0", 1, 32'h0, 32'h00500093, 0, 0);
    cycle("fill1", 1, 32'h4, 32'h00a00113, 0, 0);
    cycle("full",  1, 32'h8, 32'h00f00193, 0, 0);
    cycle("full2", 1, 32'h8, 32'h00f00193, 0, 0);
    cycle("drain0", 0, 32'h0, 32'h0, 1, 0);
    cycle("drain1", 0, 32'h0, 32'h0, 1, 0);

    for (int i = 0; i < 10; i++)
      cycle("stream", 1, 32'(4 * i), 32'h00000093 | (32'(i) << 20), 1, 0);
    cycle("stream_end", 0, 32'h0, 32'h0, 1, 0);

    cycle("fl_a", 1, 32'h10, 32'h00100093, 0, 0);
    cycle("fl_b", 1, 32'h14, 32'h00200093, 0, 0);
    cycle("flush", 1, 32'h18, 32'h00300093, 1, 1);
    cycle("post_fl", 1, 32'h40, 32'h00400093, 0, 0);
    cycle("head40", 0, 32'h0, 32'h0, 1, 0);
    cycle("fl_empty", 0, 32'h0, 32'h0, 0, 0);

    cycle("br_push", 1, 32'h100, 32'h00208463, 0, 0);
    cycle("br_head", 1, 32'h104, 32'h002081b3, 1, 0);
    cycle("add_head", 0, 32'h0, 32'h0, 1, 0);
    cycle("br_empty", 0, 32'h0, 32'h0, 0, 0);

    cycle("ar_a", 1, 32'h200, 32'h00500093, 0, 0);
    cycle("ar_b", 1, 32'h204, 32'h00600093, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    check("ar_pre.count", 64'(count), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("ar.count",     64'(count),     64'd0);
    check("ar.out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_outputs("ar_hold");
    rst = 1'b1;
    cycle("ar_push", 1, 32'h300, 32'h00700093, 0, 0);
    cycle("ar_head", 0, 32'h0, 32'h0, 1, 0);
    cycle("ar_done", 0, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 60; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    cycle("final", 0, 32'h0, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
